// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store sequencer driving a grant/rvalid memory bus.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses (adds the misalign port).
module mem_access_unit #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] alu_out,
   input  logic [31:0] rs2_data,
   output logic        stall,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic        bus_err,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic        misalign,
`endif
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        mem_we,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam bit          TO_EN   = (MAX_WAIT != 0);
   localparam logic [15:0] TO_LAST = 16'(MAX_WAIT - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [29:0] addr_q;
   logic [1:0]  off_q;
   logic        byte_q, half_q, uns_q, we_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] ldata_q, ldata_d;
   logic        lvalid_q, lvalid_d;
   logic        err_q, err_d;

   logic        start, is_b, is_h, timeout;
   logic [31:0] st_data, rsh, ext;
   logic [3:0]  st_strb;
   logic [15:0] hw;

   assign start   = (state_q == S_IDLE) && req_valid;
   assign is_b    = (req_funct3[1:0] == 2'b00);
   assign is_h    = (req_funct3[1:0] == 2'b01);
   assign timeout = TO_EN && (cnt_q == TO_LAST);

`ifdef MEM_MISALIGN_TRAP_EN
   logic mis_q, mis_d, mis_req;
   assign mis_req  = is_h ? alu_out[0]
                   : (!is_b && (alu_out[1:0] != 2'b00));
   assign misalign = mis_q;
`endif

   always_comb begin
      st_data = rs2_data;
      st_strb = 4'b1111;
      unique case (1'b1)
         is_b: begin
            st_data = {4{rs2_data[7:0]}};
            st_strb = 4'b0001 << alu_out[1:0];
         end
         is_h: begin
            st_data = {2{rs2_data[15:0]}};
            st_strb = 4'b0011 << {alu_out[1], 1'b0};
         end
         default: ;
      endcase
      if (!req_we) st_strb = 4'b0000;
   end

   // Lane extraction uses the offset captured with the request.
   assign rsh = mem_rdata >> {off_q, 3'b000};
   assign hw  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      ext = mem_rdata;
      unique case (1'b1)
         byte_q:  ext = uns_q ? {24'd0, rsh[7:0]}
                               : {{24{rsh[7]}}, rsh[7:0]};
         half_q:  ext = uns_q ? {16'd0, hw} : {{16{hw[15]}}, hw};
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ldata_d  = ldata_q;
      lvalid_d = 1'b0;
      err_d    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_REQ;
               cnt_d   = 16'd0;
`ifdef MEM_MISALIGN_TRAP_EN
               if (mis_req) begin
                  state_d  = S_DONE;
                  mis_d    = 1'b1;
                  lvalid_d = !req_we;
                  if (!req_we) ldata_d = 32'd0;
               end
`endif
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + 16'd1;
            if (mem_gnt) begin
               if (we_q) begin
                  state_d = S_DONE;
               end else if (mem_rvalid) begin
                  state_d  = S_DONE;
                  ldata_d  = ext;
                  lvalid_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end else if (timeout) begin
               state_d  = S_DONE;
               err_d    = 1'b1;
               lvalid_d = !we_q;
               if (!we_q) ldata_d = 32'd0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (mem_rvalid) begin
               state_d  = S_DONE;
               ldata_d  = ext;
               lvalid_d = 1'b1;
            end else if (timeout) begin
               state_d  = S_DONE;
               err_d    = 1'b1;
               lvalid_d = 1'b1;
               ldata_d  = 32'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 16'd0;
         addr_q   <= 30'd0;
         off_q    <= 2'd0;
         byte_q   <= 1'b0;
         half_q   <= 1'b0;
         uns_q    <= 1'b0;
         we_q     <= 1'b0;
         wdata_q  <= 32'd0;
         wstrb_q  <= 4'd0;
         ldata_q  <= 32'd0;
         lvalid_q <= 1'b0;
         err_q    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
         mis_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ldata_q  <= ldata_d;
         lvalid_q <= lvalid_d;
         err_q    <= err_d;
`ifdef MEM_MISALIGN_TRAP_EN
         mis_q    <= mis_d;
`endif
         if (start) begin
            addr_q  <= alu_out[31:2];
            off_q   <= alu_out[1:0];
            byte_q  <= is_b;
            half_q  <= is_h;
            uns_q   <= req_funct3[2];
            we_q    <= req_we;
            wdata_q <= st_data;
            wstrb_q <= st_strb;
         end
      end
   end

   // Gate with reset so a held req_valid cannot raise stall during reset.
   assign stall = rst & (start || (state_q == S_REQ)
                               || (state_q == S_WAIT));

   assign mem_req    = (state_q == S_REQ);
   assign mem_addr   = {addr_q, 2'b00};
   assign mem_wdata  = wdata_q;
   assign mem_wstrb  = wstrb_q;
   assign mem_we     = we_q;
   assign load_valid = lvalid_q;
   assign load_data  = ldata_q;
   assign bus_err    = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus multi-cycle sequences
// for mem_access_unit built with MAX_WAIT=4.
module tb_mem_access_unit;
   localparam int MW = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] alu_out, rs2_data;
   logic        stall, load_valid, bus_err;
   logic [31:0] load_data;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign;
`endif
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we),
      .req_funct3(req_funct3), .alu_out(alu_out),
      .rs2_data(rs2_data), .stall(stall),
      .load_valid(load_valid), .load_data(load_data),
      .bus_err(bus_err),
`ifdef MEM_MISALIGN_TRAP_EN
      .misalign(misalign),
`endif
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_we(mem_we), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a, d, rd;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_strb;
      logic [31:0] e_ld;
   } vec_t;

   typedef struct {
      int          stalls, reqs, lvs, errs, extra, mis;
      logic [31:0] addr, wdata, ld, ld_after;
      logic [3:0]  wstrb;
      logic        we;
      bit          done;
   } res_t;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic we,
      input logic [2:0] f3, input logic [31:0] a, d, rd, ea, ew,
      input logic [3:0] es, input logic [31:0] el);
      vec_t v;
      v.name = n; v.we = we; v.f3 = f3; v.a = a; v.d = d;
      v.rd = rd; v.e_addr = ea; v.e_wdata = ew;
      v.e_strb = es; v.e_ld = el;
      return v;
   endfunction

   // Starts and ends at posedge+1; bus answers with grant after gdly
   // REQ cycles (<0 never) and rvalid rdly cycles after grant (<0 never).
   task automatic run_txn(input logic we, input logic [2:0] f3,
      input logic [31:0] a, d, rd, input int gdly, input int rdly,
      input bit stray, output res_t r);
      int reqn;
      int gcyc;
      r = '{default: 0};
      reqn = 0;
      gcyc = -1;
      req_valid = 1'b1; req_we = we; req_funct3 = f3;
      alu_out = a; rs2_data = d; mem_rdata = rd;
      for (int c = 0; c < 20 && !r.done; c++) begin
         mem_gnt = mem_req && (gdly >= 0) && (reqn == gdly);
         if (mem_gnt) gcyc = c;
         mem_rvalid = !we && (rdly >= 0) && (gcyc >= 0)
                      && (c == gcyc + rdly);
         @(negedge clk);
         if (stall) r.stalls++;
         if (mem_req) begin
            r.reqs++;
            reqn++;
            r.addr = mem_addr; r.wdata = mem_wdata;
            r.wstrb = mem_wstrb; r.we = mem_we;
         end
         if (load_valid) r.lvs++;
         if (bus_err) r.errs++;
`ifdef MEM_MISALIGN_TRAP_EN
         if (misalign) r.mis++;
`endif
         if (c > 0 && !stall) begin
            r.done = 1'b1;
            r.ld = load_data;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      mem_gnt = stray; mem_rvalid = stray;
      mem_rdata = 32'h55AA55AA;
      repeat (2) begin
         @(negedge clk);
         if (stall || load_valid || bus_err || mem_req) r.extra++;
         @(posedge clk); #1;
      end
      r.ld_after = load_data;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
   endtask

   vec_t vt[16];
   res_t r;
   logic [31:0] last_ld;

   initial begin
      vt[0]  = mk("lw",   0, 3'b010, 32'h1004, 0, 32'hDEADBEEF,
                  32'h1004, 0, 4'b0000, 32'hDEADBEEF);
      vt[1]  = mk("sb3",  1, 3'b000, 32'h2003, 32'hA5, 0,
                  32'h2000, 32'hA5A5A5A5, 4'b1000, 0);
      vt[2]  = mk("lb1",  0, 3'b000, 32'h11, 0, 32'h00008000,
                  32'h10, 0, 4'b0000, 32'hFFFFFF80);
      vt[3]  = mk("lbu1", 0, 3'b100, 32'h11, 0, 32'h00008000,
                  32'h10, 0, 4'b0000, 32'h00000080);
      vt[4]  = mk("lh2",  0, 3'b001, 32'h12, 0, 32'h80010000,
                  32'h10, 0, 4'b0000, 32'hFFFF8001);
      vt[5]  = mk("lhu2", 0, 3'b101, 32'h12, 0, 32'h80010000,
                  32'h10, 0, 4'b0000, 32'h00008001);
      vt[6]  = mk("lb0",  0, 3'b000, 32'h10, 0, 32'h00000080,
                  32'h10, 0, 4'b0000, 32'hFFFFFF80);
      vt[7]  = mk("lb3",  0, 3'b000, 32'h13, 0, 32'h7F000000,
                  32'h10, 0, 4'b0000, 32'h0000007F);
      vt[8]  = mk("sh2",  1, 3'b001, 32'h2002, 32'h1234ABCD, 0,
                  32'h2000, 32'hABCDABCD, 4'b1100, 0);
      vt[9]  = mk("sw",   1, 3'b010, 32'h3008, 32'hCAFEF00D, 0,
                  32'h3008, 32'hCAFEF00D, 4'b1111, 0);
      vt[10] = mk("sb0",  1, 3'b000, 32'h2000, 32'hFFFFFF5A, 0,
                  32'h2000, 32'h5A5A5A5A, 4'b0001, 0);
      vt[11] = mk("lw011", 0, 3'b011, 32'h40, 0, 32'h11223344,
                  32'h40, 0, 4'b0000, 32'h11223344);
      vt[12] = mk("sw110", 1, 3'b110, 32'h44, 32'h01020304, 0,
                  32'h44, 32'h01020304, 4'b1111, 0);
      vt[13] = mk("lh0",  0, 3'b001, 32'h10, 0, 32'h0000FFFE,
                  32'h10, 0, 4'b0000, 32'hFFFFFFFE);
      vt[14] = mk("lhu0", 0, 3'b101, 32'h10, 0, 32'h0000FFFE,
                  32'h10, 0, 4'b0000, 32'h0000FFFE);
      vt[15] = mk("sb1",  1, 3'b000, 32'h2001, 32'h000000C3, 0,
                  32'h2000, 32'hC3C3C3C3, 4'b0010, 0);

      // Reset with live-looking inputs: everything must read zero.
      rst = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      alu_out = 32'hFFFFFFFF; rs2_data = 32'hFFFFFFFF;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
      #22;
      chk("rst.stall", stall, 0);
      chk("rst.load_valid", load_valid, 0);
      chk("rst.load_data", load_data, 0);
      chk("rst.bus_err", bus_err, 0);
      chk("rst.mem_req", mem_req, 0);
      chk("rst.mem_addr", mem_addr, 0);
      chk("rst.mem_wdata", mem_wdata, 0);
      chk("rst.mem_wstrb", mem_wstrb, 0);
      chk("rst.mem_we", mem_we, 0);
      @(posedge clk); #1;
      req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;

      last_ld = 32'd0;
      for (int i = 0; i < 16; i++) begin
         run_txn(vt[i].we, vt[i].f3, vt[i].a, vt[i].d, vt[i].rd,
                 0, 0, 1'b0, r);
         chk({vt[i].name, ".done"}, r.done, 1);
         chk({vt[i].name, ".stalls"}, r.stalls, 2);
         chk({vt[i].name, ".reqs"}, r.reqs, 1);
         chk({vt[i].name, ".addr"}, r.addr, vt[i].e_addr);
         chk({vt[i].name, ".we"}, r.we, vt[i].we);
         chk({vt[i].name, ".wstrb"}, r.wstrb, vt[i].e_strb);
         chk({vt[i].name, ".errs"}, r.errs, 0);
         chk({vt[i].name, ".extra"}, r.extra, 0);
         if (vt[i].we) begin
            chk({vt[i].name, ".wdata"}, r.wdata, vt[i].e_wdata);
            chk({vt[i].name, ".lvs"}, r.lvs, 0);
            chk({vt[i].name, ".ld_hold"}, r.ld, last_ld);
         end else begin
            chk({vt[i].name, ".lvs"}, r.lvs, 1);
            chk({vt[i].name, ".ld"}, r.ld, vt[i].e_ld);
            last_ld = vt[i].e_ld;
         end
      end

      // LW with rvalid two cycles after grant.
      run_txn(0, 3'b010, 32'h1004, 0, 32'hDEADBEEF, 0, 2, 1'b0, r);
      chk("lw_wait.done", r.done, 1);
      chk("lw_wait.stalls", r.stalls, 4);
      chk("lw_wait.addr", r.addr, 32'h1004);
      chk("lw_wait.lvs", r.lvs, 1);
      chk("lw_wait.ld", r.ld, 32'hDEADBEEF);

      // Grant never comes: timeout from REQ, then a stray response.
      run_txn(0, 3'b010, 32'h500, 0, 32'h77777777, -1, 0, 1'b1, r);
      chk("to_req.done", r.done, 1);
      chk("to_req.reqs", r.reqs, MW);
      chk("to_req.stalls", r.stalls, MW + 1);
      chk("to_req.errs", r.errs, 1);
      chk("to_req.lvs", r.lvs, 1);
      chk("to_req.ld", r.ld, 0);
      chk("to_req.stray_extra", r.extra, 0);
      chk("to_req.stray_ld", r.ld_after, 0);

      // Timeout while waiting for read data.
      run_txn(0, 3'b010, 32'h600, 0, 32'h13579BDF, 0, 0, 1'b0, r);
      chk("pre_to.ld", r.ld, 32'h13579BDF);
      run_txn(0, 3'b010, 32'h604, 0, 32'h2468ACE0, 0, -1, 1'b1, r);
      chk("to_wait.done", r.done, 1);
      chk("to_wait.reqs", r.reqs, 1);
      chk("to_wait.stalls", r.stalls, MW + 1);
      chk("to_wait.errs", r.errs, 1);
      chk("to_wait.ld", r.ld, 0);
      chk("to_wait.stray_extra", r.extra, 0);

      // Completion on the last allowed cycle wins over timeout.
      run_txn(1, 3'b010, 32'h700, 32'h0F0F0F0F, 0, MW - 1, 0, 1'b0, r);
      chk("last_st.reqs", r.reqs, MW);
      chk("last_st.errs", r.errs, 0);
      chk("last_st.lvs", r.lvs, 0);
      run_txn(0, 3'b010, 32'h704, 0, 32'h31415926, MW - 2, 1, 1'b0, r);
      chk("last_ld.stalls", r.stalls, MW + 1);
      chk("last_ld.errs", r.errs, 0);
      chk("last_ld.ld", r.ld, 32'h31415926);

      // Reset asserted while in WAIT.
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
      alu_out = 32'h800; mem_rdata = 32'h12345678;
      @(posedge clk); #1;
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("rst_wait.pre_stall", stall, 1);
      rst = 1'b0;
      #1;
      chk("rst_wait.stall", stall, 0);
      chk("rst_wait.mem_req", mem_req, 0);
      chk("rst_wait.load_data", load_data, 0);
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      mem_rvalid = 1'b1; mem_gnt = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_wait.no_lv", load_valid, 0);
         @(posedge clk); #1;
      end
      mem_rvalid = 1'b0; mem_gnt = 1'b0;

      // Reset asserted while requesting drops mem_req at once.
      req_valid = 1'b1; req_we = 1'b1; alu_out = 32'h900;
      @(posedge clk); #1;
      chk("rst_req.pre_req", mem_req, 1);
      rst = 1'b0;
      #1;
      chk("rst_req.mem_req", mem_req, 0);
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

`ifdef MEM_MISALIGN_TRAP_EN
      run_txn(0, 3'b010, 32'h600, 0, 32'h0BADCAFE, 0, 0, 1'b0, r);
      run_txn(0, 3'b010, 32'h1002, 0, 32'hA1B2C3D4, 0, 0, 1'b0, r);
      chk("mis_lw.done", r.done, 1);
      chk("mis_lw.reqs", r.reqs, 0);
      chk("mis_lw.stalls", r.stalls, 1);
      chk("mis_lw.mis", r.mis, 1);
      chk("mis_lw.lvs", r.lvs, 1);
      chk("mis_lw.ld", r.ld, 0);
      run_txn(1, 3'b001, 32'h2001, 32'h5678, 0, 0, 0, 1'b0, r);
      chk("mis_sh.reqs", r.reqs, 0);
      chk("mis_sh.mis", r.mis, 1);
      chk("mis_sh.lvs", r.lvs, 0);
      run_txn(0, 3'b001, 32'h12, 0, 32'h80010000, 0, 0, 1'b0, r);
      chk("al_lh.mis", r.mis, 0);
      chk("al_lh.ld", r.ld, 32'hFFFF8001);
`else
      run_txn(0, 3'b010, 32'h1002, 0, 32'hA1B2C3D4, 0, 0, 1'b0, r);
      chk("mis_lw.addr", r.addr, 32'h1000);
      chk("mis_lw.ld", r.ld, 32'hA1B2C3D4);
      run_txn(0, 3'b001, 32'h13, 0, 32'hBEEF1234, 0, 0, 1'b0, r);
      chk("mis_lh.ld", r.ld, 32'hFFFFBEEF);
      run_txn(1, 3'b001, 32'h2001, 32'h5678, 0, 0, 0, 1'b0, r);
      chk("mis_sh.wdata", r.wdata, 32'h56785678);
      chk("mis_sh.wstrb", r.wstrb, 4'b0011);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
